rv32m_muldiv_unit: RTL and testbench
====================================

Name: rv32m_muldiv_unit

Overview:
Iterative RV32M multiply/divide execute unit for the multicycle datapath. It consumes the two register-file read operands and a 3-bit op code (funct3) when started. Multiplication uses radix-2 shift-add and division uses restoring division, one bit per cycle. The 32-bit result and the captured destination register index are held stable for the register-file write port (wd / addr3 / we path).

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN (only 32 is verified)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE or DONE
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  XLEN  operand A (multiplicand / dividend)
rs2_val  input  XLEN  operand B (multiplier / divisor)
rd_in  input  5  destination index, captured with start
busy  output  1  high in RUN and FIX states
done  output  1  single-cycle pulse, result valid
result  output  XLEN  registered result, held until next accepted start or reset
rd_out  output  5  registered copy of rd_in for the accepted operation

Behaviour:
- Reset: on rst at a rising edge, state=IDLE and busy=0, done=0, result=0, rd_out=0. Internal accumulators and counter are cleared. rst has priority over start and over any in-flight operation. An aborted operation never produces done.
- States: IDLE, RUN, FIX, DONE. DONE lasts exactly one cycle, then returns to IDLE unless a new start is accepted.
- Accept: start=1 in IDLE or DONE captures op, rs1_val, rs2_val and rd_in (into rd_out) at that edge (E0). start while busy=1 is ignored and has no side effects.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU treat both as unsigned.
- Magnitudes: signed operands are converted to magnitude at E0, and negate flags are recorded.
  - Product sign = signA XOR signB.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
- Multiply: 2*XLEN-bit unsigned accumulator; one multiplier bit per RUN cycle.
  - MUL returns the low XLEN bits of the signed product.
  - MULH, MULHSU and MULHU return the high XLEN bits of the correctly signed 2*XLEN product.
- Divide: restoring division, one quotient bit per RUN cycle on magnitudes.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Timing, normal path:
  - E0: IDLE/DONE -> RUN, counter=0.
  - E1..E32: one iteration each; at E32 the state goes to FIX.
  - E33: sign correction applied, result registered, state=DONE.
  - done=1 and result valid in the cycle following E33, i.e. 33 cycles after E0.
- Special cases resolved at E0 (state goes directly to DONE, done=1 one cycle after E0):
  - Divide by zero (rs2_val=0): DIV/DIVU return all-ones; REM/REMU return rs1_val.
  - Signed overflow, DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
  - Multiply has no special cases.
- Back-to-back: a start during DONE is accepted. done then falls next cycle, and result holds the previous value until the new completion.
- busy = (state==RUN || state==FIX). busy and done are never high together.
- Outputs are purely registered, with no combinational path from inputs to outputs.

Test Plan:
- Reset, then MUL 7 * 0xFFFFFFFD (-3) -> done exactly 33 cycles after start edge, result=0xFFFFFFEB, rd_out=rd_in (e.g. 5'd9), busy high for 33 cycles.
- A=B=0xFFFFFFFF with MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each done after 33 cycles.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done one cycle after start. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, done one cycle after start.
- start pulsed at cycle 10 of a running MUL with different operands -> ignored; the original result completes unchanged at cycle 33.
- rst asserted at iteration 10 -> next cycle busy=0, done=0, result=0, and no done pulse follows. A start in the DONE cycle is accepted, with the new result 33 cycles later.

Source files
------------

// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the multicycle datapath and the RV32M
// multiply/divide unit: operands and funct3 in, result and rd index out.
interface rv32m_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, op, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fixed up at the end.
module rv32m_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  rv32m_muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        op_q;
  logic              neg_res;
  logic              neg_rem;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;

  // Operand decode on the incoming request
  logic            in_div;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_result;
  logic            accept;

  assign in_div   = bus.op[2];
  assign a_signed = in_div ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
  assign b_signed = in_div ? ~bus.op[0] : ~bus.op[1];
  assign a_neg    = a_signed & bus.rs1_val[XLEN-1];
  assign b_neg    = b_signed & bus.rs2_val[XLEN-1];
  assign a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
  assign b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;

  assign div_zero = in_div && (bus.rs2_val == '0);
  assign div_ovf  = in_div && ~bus.op[0] && (bus.rs1_val == INT_MIN) && (bus.rs2_val == '1);
  assign special  = div_zero | div_ovf;

  // Overflowed DIV yields INT_MIN, which is exactly rs1_val in that case
  always_comb begin
    special_result = '0;
    if (bus.op[1]) begin
      special_result = div_zero ? bus.rs1_val : '0;
    end else begin
      special_result = div_zero ? '1 : bus.rs1_val;
    end
  end

  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  // One iteration step for each algorithm
  logic            is_div;
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]   div_shift;
  logic            div_ok;
  logic [XLEN-1:0] div_rem;
  logic [2*XLEN-1:0] div_next;

  assign is_div    = op_q[2];
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign mul_next  = {mul_sum, acc[XLEN-1:1]};
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd});
  assign div_rem   = div_ok ? XLEN'(div_shift - {1'b0, opnd}) : div_shift[XLEN-1:0];
  assign div_next  = {div_rem, acc[XLEN-2:0], div_ok};

  // Sign correction of the finished magnitude result
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_result;

  assign prod = neg_res ? -acc : acc;
  assign quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    if (is_div) begin
      fix_result = op_q[1] ? rem : quo;
    end else if (op_q[1:0] == 2'b00) begin
      fix_result = prod[XLEN-1:0];
    end else begin
      fix_result = prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = special ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_next = special ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // busy/done are flopped from the next state so outputs never see inputs combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_next == RUN) || (state_next == FIX);
      done_q <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      op_q    <= bus.op;
      rd_q    <= bus.rd_in;
      cnt     <= '0;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      opnd    <= in_div ? b_mag : a_mag;
      acc     <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
      if (special) begin
        result_q <= special_result;
      end
    end else if (state == RUN) begin
      acc <= is_div ? div_next : mul_next;
      cnt <= cnt + 1'b1;
    end else if (state == FIX) begin
      result_q <= fix_result;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: expected results are queued at
// issue time and compared against result/rd_out/latency when done fires.
module tb_rv32m_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rv32m_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  rv32m_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  // Independent reference using wide native arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic signed [63:0] ua;
    logic signed [63:0] ub;
    logic signed [63:0] p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (op)
      OP_MUL:    begin p = sa * sbv; model = p[31:0]; end
      OP_MULH:   begin p = sa * sbv; model = p[63:32]; end
      OP_MULHSU: begin p = sa * ub;  model = p[63:32]; end
      OP_MULHU:  begin p = ua * ub;  model = p[63:32]; end
      OP_DIV:    begin
        if (b == 0) model = 32'hFFFF_FFFF;
        else if (ovf) model = a;
        else begin p = sa / sbv; model = p[31:0]; end
      end
      OP_DIVU:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    begin
        if (b == 0) model = a;
        else if (ovf) model = 32'h0;
        else begin p = sa % sbv; model = p[31:0]; end
      end
      default:   model = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
    exp_t e;
    e.res = exp_res;
    e.rd  = rd;
    e.lat = exp_lat;
    sb.push_back(e);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Waits for done with a cycle budget; optionally pokes a stray start mid-run
  task automatic wait_done(input int inject_at, output logic got, output int lat,
                           output int busy_cnt, output int overlap);
    got = 1'b0;
    lat = -1;
    busy_cnt = 0;
    overlap = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        got = 1'b1;
        lat = i;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (i == inject_at) begin
        bus.start   = 1'b1;
        bus.op      = OP_MULHU;
        bus.rs1_val = 32'hDEAD_BEEF;
        bus.rs2_val = 32'h0000_0003;
        bus.rd_in   = 5'd30;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++;
    if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    n_tests++;
    if (bus.result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_result got %h want 0", bus.result); end
    n_tests++;
    if (bus.rd_out !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_rd got %0d want 0", bus.rd_out); end
  endtask

  task automatic test_table(input string name, input vec_t vecs[]);
    logic got;
    int lat, bc, ov;
    exp_t e;
    for (int k = 0; k < vecs.size(); k++) begin
      drive_op(vecs[k].op, vecs[k].a, vecs[k].b, 5'(k + 9), vecs[k].res, vecs[k].lat);
      wait_done(-1, got, lat, bc, ov);
      e = sb.pop_front();
      n_tests++;
      if (got !== 1'b1) begin n_fail++; $display("[TB] FAIL %s[%0d]_timeout no done within budget", name, k); end
      n_tests++;
      if (lat !== e.lat) begin n_fail++; $display("[TB] FAIL %s[%0d]_latency got %0d want %0d", name, k, lat, e.lat); end
      n_tests++;
      if (bus.result !== e.res) begin n_fail++; $display("[TB] FAIL %s[%0d]_result got %h want %h", name, k, bus.result, e.res); end
      n_tests++;
      if (bus.rd_out !== e.rd) begin n_fail++; $display("[TB] FAIL %s[%0d]_rd got %0d want %0d", name, k, bus.rd_out, e.rd); end
      n_tests++;
      if (bc !== e.lat || ov !== 0) begin n_fail++; $display("[TB] FAIL %s[%0d]_busy busy_cycles %0d overlap %0d want %0d/0", name, k, bc, ov, e.lat); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mul();
    vec_t v[] = '{
      '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
      '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
      '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33},
      '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
      '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33}
    };
    test_table("mul", v);
  endtask

  task automatic test_div();
    vec_t v[] = '{
      '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33},
      '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33},
      '{OP_DIVU, 32'd100,       32'd7,         32'd14,        33},
      '{OP_REMU, 32'd100,       32'd7,         32'd2,         33}
    };
    test_table("div", v);
  endtask

  task automatic test_special();
    vec_t v[] = '{
      '{OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 0},
      '{OP_REM,  32'd5,         32'd0,         32'd5,         0},
      '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0},
      '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0},
      '{OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33}
    };
    test_table("special", v);
  endtask

  task automatic test_random();
    vec_t v[] = new[16];
    for (int k = 0; k < 16; k++) begin
      v[k].op  = 3'($urandom_range(0, 7));
      v[k].a   = $urandom();
      v[k].b   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
      v[k].res = model(v[k].op, v[k].a, v[k].b);
      v[k].lat = (v[k].op[2] && v[k].b == 0) ? 0 : 33;
    end
    test_table("random", v);
  endtask

  task automatic test_ignore_start();
    logic got;
    int lat, bc, ov;
    exp_t e;
    drive_op(OP_MUL, 32'h0000_1234, 32'h0000_0010, 5'd11, 32'h0001_2340, 33);
    wait_done(9, got, lat, bc, ov);
    e = sb.pop_front();
    n_tests++;
    if (got !== 1'b1 || lat !== e.lat) begin n_fail++; $display("[TB] FAIL ignore_latency got %0d want %0d", lat, e.lat); end
    n_tests++;
    if (bus.result !== e.res) begin n_fail++; $display("[TB] FAIL ignore_result got %h want %h", bus.result, e.res); end
    n_tests++;
    if (bus.rd_out !== e.rd) begin n_fail++; $display("[TB] FAIL ignore_rd got %0d want %0d", bus.rd_out, e.rd); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    int seen = 0;
    bus.start   = 1'b1;
    bus.op      = OP_MUL;
    bus.rs1_val = 32'h0001_2345;
    bus.rs2_val = 32'h0000_0777;
    bus.rd_in   = 5'd17;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_flags busy %b done %b want 0/0", bus.busy, bus.done); end
    n_tests++;
    if (bus.result !== 32'h0) begin n_fail++; $display("[TB] FAIL abort_result got %h want 0", bus.result); end
    n_tests++;
    if (bus.rd_out !== 5'd0) begin n_fail++; $display("[TB] FAIL abort_rd got %0d want 0", bus.rd_out); end
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen++;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("[TB] FAIL abort_no_done got %0d done cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic got;
    int lat, bc, ov;
    exp_t e;
    drive_op(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    wait_done(-1, got, lat, bc, ov);
    e = sb.pop_front();
    n_tests++;
    if (got !== 1'b1 || bus.result !== e.res) begin n_fail++; $display("[TB] FAIL b2b_first got %h want %h", bus.result, e.res); end
    drive_op(OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 33);
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_accept done %b busy %b want 0/1", bus.done, bus.busy); end
    n_tests++;
    if (bus.result !== 32'd14) begin n_fail++; $display("[TB] FAIL b2b_hold got %h want %h", bus.result, 32'd14); end
    wait_done(-1, got, lat, bc, ov);
    e = sb.pop_front();
    n_tests++;
    if (got !== 1'b1 || lat !== e.lat) begin n_fail++; $display("[TB] FAIL b2b_latency got %0d want %0d", lat, e.lat); end
    n_tests++;
    if (bus.result !== e.res || bus.rd_out !== e.rd) begin n_fail++; $display("[TB] FAIL b2b_second got %h/%0d want %h/%0d", bus.result, bus.rd_out, e.res, e.rd); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in   = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
